// File: rtl/counter_seq_pkg.sv
// Shared types for the repeating count sequencer.
// Holds the controller state encoding and the count width.
package counter_seq_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        cnt_t first;
        cnt_t last;
    } span_t;

endpackage

// File: rtl/counter_4bit.sv
// Free-running 4-bit up counter with synchronous load.
// Wraps 15 -> 0 when not loading.
module counter_4bit
    import counter_seq_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  cnt_t load_data,
    output cnt_t count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_data;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer running start..end count passes on counter_4bit.
// Repeats a pass req_repeat extra times, then pulses done.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CNT_W-1:0]    req_start,
    input  logic [CNT_W-1:0]    req_end,
    input  logic [REPEAT_W-1:0] req_repeat,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    count_o
);

    state_t              state;
    state_t              state_nxt;
    span_t               span_q;
    logic [REPEAT_W-1:0] passes_q;
    logic                load;
    cnt_t                load_data;
    cnt_t                count;
    logic                accept;
    logic                at_end;
    logic                run_abort;
    logic                run_last;
    logic                run_rpt;

    counter_4bit u_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_data (load_data),
        .count     (count)
    );

    assign accept = req_valid && (state == ST_IDLE);
    assign at_end = (count == span_q.last);

    // Mutually exclusive RUN outcomes; abort beats an end match.
    assign run_abort = (state == ST_RUN) && abort;
    assign run_last  = (state == ST_RUN) && !abort
                     && at_end && (passes_q == '0);
    assign run_rpt   = (state == ST_RUN) && !abort
                     && at_end && (passes_q != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            span_q   <= '0;
            passes_q <= '0;
        end else if (accept) begin
            span_q   <= '{first: req_start, last: req_end};
            passes_q <= req_repeat;
        end else if (run_rpt) begin
            passes_q <= passes_q - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                unique case (1'b1)
                    run_abort: state_nxt = ST_IDLE;
                    run_last:  state_nxt = ST_DONE;
                    default:   state_nxt = ST_RUN;
                endcase
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter free-runs; hold it by reloading its own value.
    always_comb begin
        load      = 1'b1;
        load_data = count;
        unique case (state)
            ST_LOAD: begin
                if (!abort) begin
                    load_data = span_q.first;
                end
            end
            ST_RUN: begin
                unique case (1'b1)
                    run_rpt:   load_data = span_q.first;
                    run_abort: load      = 1'b1;
                    run_last:  load      = 1'b1;
                    default:   load      = 1'b0;
                endcase
            end
            default: begin
                load = 1'b1;
            end
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
    end

    assign count_o = count;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: directed and random jobs
// checked against a pass-list model built from the job rules.
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_start = '0;
    logic [3:0] req_end = '0;
    logic [3:0] req_repeat = '0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] count_o;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] model_cnt = '0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.REPEAT_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_start  (req_start),
        .req_end    (req_end),
        .req_repeat (req_repeat),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .count_o    (count_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // abort_at: -2 none, -1 during LOAD, >=0 index of RUN sample
    task automatic run_job(input logic [3:0] s,
                           input logic [3:0] e,
                           input logic [3:0] rep,
                           input int abort_at,
                           input bit linger);
        logic [3:0] q[$];
        logic [3:0] exp_v;
        int len;
        int n;
        int idx;
        len = ((int'(e) - int'(s) + 16) % 16) + 1;
        for (int p = 0; p <= int'(rep); p++)
            for (int k = 0; k < len; k++)
                q.push_back(4'((int'(s) + k) % 16));

        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: got %b want 1", req_ready);
        end
        req_valid  = 1'b1;
        req_start  = s;
        req_end    = e;
        req_repeat = rep;
        step();
        req_valid  = 1'b0;
        req_start  = 4'($urandom);
        req_end    = 4'($urandom);
        req_repeat = 4'($urandom);
        abort      = (abort_at == -1);

        checks++;
        if ({busy, req_ready, done, count_o} !==
            {1'b1, 1'b0, 1'b0, model_cnt}) begin
            errors++;
            $display("FAIL load_state: got b%b r%b d%b c%0d want 1 0 0 %0d",
                     busy, req_ready, done, count_o, model_cnt);
        end

        if (abort_at == -1) begin
            step();
            abort = 1'b0;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({busy, req_ready, done, count_o} !==
                    {1'b0, 1'b1, 1'b0, model_cnt}) begin
                    errors++;
                    $display("FAIL load_abort: got b%b r%b d%b c%0d want 0 1 0 %0d",
                             busy, req_ready, done, count_o, model_cnt);
                end
                if (linger) step();
            end
            return;
        end

        n   = 0;
        idx = 0;
        while (1) begin
            step();
            n++;
            if (done === 1'b1 || n > 300) break;
            if (q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL run_overrun: cycle %0d count %0d", n, count_o);
                break;
            end
            exp_v = q.pop_front();
            checks++;
            if ({busy, req_ready, count_o} !== {1'b1, 1'b0, exp_v}) begin
                errors++;
                $display("FAIL run_count[%0d]: got b%b r%b c%0d want 1 0 %0d",
                         idx, busy, req_ready, count_o, exp_v);
            end
            model_cnt = exp_v;
            if (idx == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if ({busy, req_ready, done, count_o} !==
                        {1'b0, 1'b1, 1'b0, model_cnt}) begin
                        errors++;
                        $display("FAIL run_abort: got b%b r%b d%b c%0d want 0 1 0 %0d",
                                 busy, req_ready, done, count_o, model_cnt);
                    end
                    if (linger) step();
                end
                return;
            end
            idx++;
        end

        checks++;
        if (n !== 1 + (int'(rep) + 1) * len) begin
            errors++;
            $display("FAIL latency: got %0d want %0d",
                     n, 1 + (int'(rep) + 1) * len);
        end
        checks++;
        if ({done, busy, req_ready, count_o} !==
            {1'b1, 1'b1, 1'b0, e}) begin
            errors++;
            $display("FAIL done_state: got d%b b%b r%b c%0d want 1 1 0 %0d",
                     done, busy, req_ready, count_o, e);
        end
        model_cnt = e;
        if (linger) begin
            step();
            checks++;
            if ({done, busy, req_ready, count_o} !==
                {1'b0, 1'b0, 1'b1, e}) begin
                errors++;
                $display("FAIL post_done: got d%b b%b r%b c%0d want 0 0 1 %0d",
                         done, busy, req_ready, count_o, e);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, req_ready, done, count_o} !== 7'b0_1_0_0000) begin
            errors++;
            $display("FAIL reset_outputs: got b%b r%b d%b c%0d want 0 1 0 0",
                     busy, req_ready, done, count_o);
        end
        step();
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if ({busy, req_ready, done, count_o} !== 7'b0_1_0_0000) begin
            errors++;
            $display("FAIL reset_release: got b%b r%b d%b c%0d want 0 1 0 0",
                     busy, req_ready, done, count_o);
        end
        model_cnt = '0;
    endtask

    task automatic test_basic();
        run_job(4'd3, 4'd6, 4'd0, -2, 1'b1);
        run_job(4'd14, 4'd1, 4'd0, -2, 1'b1);
        step();
        checks++;
        if (count_o !== 4'd1) begin
            errors++;
            $display("FAIL idle_hold: got %0d want 1", count_o);
        end
        run_job(4'd5, 4'd5, 4'd2, -2, 1'b1);
    endtask

    task automatic test_abort();
        run_job(4'd0, 4'd9, 4'd1, 14, 1'b1);
        run_job(4'd2, 4'd8, 4'd0, -1, 1'b1);
        abort = 1'b1;
        run_job(4'd1, 4'd3, 4'd0, -2, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_job(4'd4, 4'd7, 4'd1, -2, 1'b0);
        req_valid  = 1'b1;
        req_start  = 4'd9;
        req_end    = 4'd11;
        req_repeat = 4'd0;
        checks++;
        if ({done, req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_done_ready: got d%b r%b want 1 0",
                     done, req_ready);
        end
        step();
        checks++;
        if ({busy, req_ready, done, count_o} !==
            {1'b0, 1'b1, 1'b0, 4'd7}) begin
            errors++;
            $display("FAIL b2b_idle: got b%b r%b d%b c%0d want 0 1 0 7",
                     busy, req_ready, done, count_o);
        end
        run_job(4'd9, 4'd11, 4'd0, -2, 1'b1);
    endtask

    task automatic test_random();
        logic [3:0] s;
        logic [3:0] e;
        logic [3:0] rep;
        int len;
        int ab;
        for (int j = 0; j < 30; j++) begin
            s   = 4'($urandom);
            e   = 4'($urandom);
            rep = ($urandom_range(0, 7) == 0) ? 4'($urandom)
                                              : 4'($urandom_range(0, 3));
            len = ((int'(e) - int'(s) + 16) % 16) + 1;
            ab  = -2;
            if ($urandom_range(0, 3) == 0)
                ab = $urandom_range(0, (int'(rep) + 1) * len - 1);
            else if ($urandom_range(0, 9) == 0)
                ab = -1;
            run_job(s, e, rep, ab, 1'b1);
        end
    endtask

    task automatic test_reset_mid_job();
        bool_found: begin end
        req_valid  = 1'b1;
        req_start  = 4'd2;
        req_end    = 4'd12;
        req_repeat = 4'd0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (count_o === 4'd7) break;
        end
        checks++;
        if (count_o !== 4'd7 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reach_seven: got c%0d b%b want 7 1", count_o, busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, count_o} !== 6'b0_0_0000) begin
            errors++;
            $display("FAIL async_reset: got b%b d%b c%0d want 0 0 0",
                     busy, done, count_o);
        end
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({busy, req_ready, done, count_o} !== 7'b0_1_0_0000) begin
                errors++;
                $display("FAIL after_reset[%0d]: got b%b r%b d%b c%0d want 0 1 0 0",
                         i, busy, req_ready, done, count_o);
            end
        end
        model_cnt = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid_job();
        run_job(4'd8, 4'd10, 4'd1, -2, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter: REPEAT_W, default 4, width of repeat-count field.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  requester presents a count job.
REQ-005 req_ready  output  1  controller can accept a job; high only in IDLE.
REQ-006 req_start  input  4  first count value of each pass.
REQ-007 req_end  input  4  terminal count value of each pass.
REQ-008 req_repeat  input  REPEAT_W  extra passes; job runs req_repeat+1 passes.
REQ-009 abort  input  1  cancel active job.
REQ-010 busy  output  1  high in LOAD, RUN, DONE.
REQ-011 done  output  1  one-cycle pulse on normal job completion.
REQ-012 count_o  output  4  current counter value.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-014 Job accepted on the rising edge where req_valid && req_ready; req_start, req_end and req_repeat SHALL be latched then; inputs ignored otherwise.
REQ-015 IDLE: counter held (load=1, load_data=count); accept -> LOAD.
REQ-016 LOAD: one cycle, load=1, load_data=latched start; -> RUN; count_o = start in first RUN cycle.
REQ-017 RUN: load=0, counter increments by 1 per cycle, modulo 16 (15 -> 0).
REQ-018 RUN, count==end, passes_left>0: load start, decrement passes_left, stay RUN; next cycle count_o = start.
REQ-019 RUN, count==end, passes_left==0: hold counter, -> DONE.
REQ-020 Pass length in RUN SHALL be ((end - start) mod 16) + 1 cycles; start==end gives 1-cycle passes.
REQ-021 DONE: one cycle, done=1, counter held at end; -> IDLE.
REQ-022 Accept-to-done latency SHALL be 1 + (req_repeat+1)*(((end-start) mod 16)+1) cycles.
REQ-023 abort in LOAD or RUN: hold counter, -> IDLE next cycle, no done; abort SHALL take priority over end match.
REQ-024 abort in IDLE or DONE SHALL be ignored; abort with req_valid in IDLE SHALL NOT block acceptance.
REQ-025 No request accepted in DONE; back-to-back job accepted earliest in cycle after DONE.
REQ-026 count_o SHALL equal the sub-counter output combinationally; done and busy SHALL be glitch-free state decodes.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, passes_left=0, latched fields=0, done=0, busy=0, count_o=0.
REQ-028 req_ready SHALL be 1 on the first cycle after reset_n deasserts.
REQ-029 Reset mid-job SHALL discard the job with no done pulse.

Structure
REQ-030 Shared package counter_seq_pkg SHALL hold the FSM state enum and the 4-bit count width constant.
REQ-031 SHALL instantiate one counter_4bit as the datapath; controller drives only its load and load_data and observes count.
REQ-032 Controller SHALL treat the counter as free-running and hold it via load=count whenever not in RUN.

Verification
REQ-033 start=3,end=6,repeat=0 -> count_o 3,4,5,6 on consecutive RUN cycles; done next cycle; latency 5.
REQ-034 start=14,end=1,repeat=0 -> count_o 14,15,0,1; done after 1; count_o stays 1 in IDLE.
REQ-035 start=5,end=5,repeat=2 -> three 1-cycle RUN passes at 5; single done; latency 4.
REQ-036 start=0,end=9,repeat=1, abort at count_o=4 of pass 2 -> IDLE next cycle, no done, count_o held 4, req_ready=1.
REQ-037 req_valid held high across DONE -> req_ready=0 in DONE, second job accepted in following IDLE cycle.
REQ-038 reset_n low during RUN at count_o=7 -> count_o=0, busy=0, done never pulses, req_ready=1 after release.
